calendar_ctrl: RTL
==================

// Module: calendar_ctrl
// PURPOSE
//   Day/month calendar sequencer that drives the enable of the 4-digit BCD year counter.
//   Counts day_tick pulses through day-of-month and month with correct month lengths and leap-year February.
//   Issues a one-cycle year_en pulse on the Dec 31 -> Jan 1 rollover.
//   Accepts a day/month preset through a valid/ready handshake and rejects impossible dates.
// PARAMETERS
//   START_DAY    1   day-of-month loaded at reset (1..31, must be valid for START_MONTH in a leap year)
//   START_MONTH  1   month loaded at reset (1..12)
// PORTS
//   clk        in   1  system clock, all state on rising edge
//   rst        in   1  asynchronous active-low reset
//   day_tick   in   1  one-cycle pulse: end of current day
//   year_0..3  in   4  BCD year digits from year counter (year_0 = units)
//   set_valid  in   1  preset request; set_day/set_month held stable while high
//   set_day    in   5  preset day-of-month, binary
//   set_month  in   4  preset month, binary
//   set_ready  out  1  high when a preset can be accepted
//   set_ack    out  1  one-cycle pulse: preset loaded
//   set_err    out  1  one-cycle pulse: preset rejected, date unchanged
//   day        out  5  current day-of-month, binary 1..31
//   month      out  4  current month, binary 1..12
//   leap       out  1  combinational: current year is leap
//   year_en    out  1  one-cycle pulse to year counter en
// BEHAVIOUR
//   Reset (rst=0, async): day=START_DAY, month=START_MONTH, year_en=0, set_ack=0, set_err=0, FSM=RUN.
//   FSM states: RUN, CHECK.
//     RUN: set_ready=1. set_valid=1 -> latch set_day/set_month, go CHECK. Otherwise day_tick advances date.
//     CHECK: set_ready=0, one cycle. Valid preset -> load day/month, set_ack=1. Invalid -> set_err=1, date kept.
//     Always returns to RUN.
//   Preset valid iff 1<=set_month<=12 and 1<=set_day<=mlen(set_month), evaluated with leap at the CHECK cycle.
//   mlen: 31 for months 1,3,5,7,8,10,12; 30 for 4,6,9,11; Feb = 29 if leap, else 28.
//   Advance on day_tick:
//     day<mlen(month) -> day+1.
//     day==mlen, month<12 -> day=1, month+1.
//     day==31, month==12 -> day=1, month=1, year_en=1 in the following cycle only.
//   Latency: day/month update on the edge that samples day_tick; year_en high in the cycle after that edge.
//   The year digits therefore change two edges after the tick.
//   leap from BCD, no binary conversion. Let T = two-digit value (year_1,year_0).
//     T%4==0 iff (year_1 even and year_0 in {0,4,8}) or (year_1 odd and year_0 in {2,6}).
//   Simultaneous day_tick and set_valid in RUN: the preset wins and the tick is discarded.
//   day_tick during CHECK is discarded.
//   day_tick width >1 cycle: every high cycle in RUN counts as a tick; drivers must pulse.
//   Out-of-range state (e.g. day=30, month=2) is never reachable; on a tick it is treated as day==mlen.
//   Reset mid-CHECK aborts the preset with no ack/err pulse.
//   set_ack, set_err and year_en are never high in the same cycle.
// CONFIGURATION
//   GREGORIAN_CENTURY_EN defined:
//     T==00 is leap iff (year_3,year_2)%4==0, using the same BCD rule.
//     Otherwise leap iff T%4==0.
//   GREGORIAN_CENTURY_EN undefined: leap iff T%4==0 (T==00 always leap, Julian rule).
// TESTING
//   Reset -> day=1, month=1, year_en=0, set_ready=1.
//   Preset 12/31, one day_tick -> day=1, month=1, exactly one year_en pulse, one cycle after the tick edge.
//   Year 2024, preset 28/2, two ticks -> 29/2 then 1/3.
//   Year 2023, preset 28/2, one tick -> 1/3.
//   Preset 31/4 -> set_err pulse, date unchanged.
//   Preset 0/5 and 15/13 -> set_err pulse, date unchanged.
//   Year 1900, preset 29/2:
//     set_err with GREGORIAN_CENTURY_EN defined; set_ack without it.
//     Year 2000 -> set_ack in both builds.
//   set_valid and day_tick in the same cycle at 10/6, preset 5/7:
//     date 5/7, tick dropped, set_ready low for exactly one cycle.
//     Assert rst low mid-CHECK -> reset values, no ack/err.

Source files
------------

// File: rtl/calendar_ctrl.sv
// Day/month calendar sequencer driving the BCD year counter enable.
// Optional macro GREGORIAN_CENTURY_EN: century years leap only if year%400==0.
module calendar_ctrl #(
  parameter int START_DAY   = 1,
  parameter int START_MONTH = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       day_tick,
  input  logic [3:0] year_0,
  input  logic [3:0] year_1,
  input  logic [3:0] year_2,
  input  logic [3:0] year_3,
  input  logic       set_valid,
  input  logic [4:0] set_day,
  input  logic [3:0] set_month,
  output logic       set_ready,
  output logic       set_ack,
  output logic       set_err,
  output logic [4:0] day,
  output logic [3:0] month,
  output logic       leap,
  output logic       year_en
);

  localparam logic [4:0] RST_DAY = 5'(START_DAY);
  localparam logic [3:0] RST_MON = 4'(START_MONTH);

  typedef enum logic {RUN, CHECK} state_t;

  typedef struct packed {
    logic [4:0] d;
    logic [3:0] m;
  } preset_t;

  state_t  state;
  state_t  state_nx;
  preset_t pre;
  logic    latch;
  logic    chk;
  logic    adv;
  logic    pre_ok;
  logic    at_end;
  logic [4:0] cur_len;
  logic [4:0] pre_len;

  // BCD pair divisible by 4: tens parity selects the units set
  function automatic logic div4(
    input logic [3:0] hi,
    input logic [3:0] lo
  );
    if (hi[0])
      return (lo == 4'd2) || (lo == 4'd6);
    else
      return (lo == 4'd0) || (lo == 4'd4) ||
             (lo == 4'd8);
  endfunction

  // Month length; unknown months fall back to 31
  function automatic logic [4:0] mlen(
    input logic [3:0] m,
    input logic       lp
  );
    logic [4:0] r;
    case (m)
      4'd2:    r = lp ? 5'd29 : 5'd28;
      4'd4,
      4'd6,
      4'd9,
      4'd11:   r = 5'd30;
      default: r = 5'd31;
    endcase
    return r;
  endfunction

`ifdef GREGORIAN_CENTURY_EN
  // Century years take the rule from the upper digit pair
  always_comb begin
    if (year_1 == 4'd0 && year_0 == 4'd0)
      leap = div4(year_3, year_2);
    else
      leap = div4(year_1, year_0);
  end
`else
  logic unused_century;
  assign unused_century = ^{year_3, year_2};

  // Julian rule: every fourth year, centuries included
  always_comb begin
    leap = div4(year_1, year_0);
  end
`endif

  // Month length lookups for the live date and the pending preset
  always_comb begin
    cur_len = mlen(month, leap);
    pre_len = mlen(pre.m, leap);
    at_end  = (day >= cur_len);
    pre_ok  = (pre.m >= 4'd1) && (pre.m <= 4'd12) &&
              (pre.d >= 5'd1) && (pre.d <= pre_len);
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      state <= RUN;
    else
      state <= state_nx;
  end

  // Next state and per-cycle strobes; preset beats a tick
  always_comb begin
    state_nx  = state;
    set_ready = 1'b0;
    latch     = 1'b0;
    chk       = 1'b0;
    adv       = 1'b0;
    unique case (state)
      RUN: begin
        set_ready = 1'b1;
        if (set_valid) begin
          latch    = 1'b1;
          state_nx = CHECK;
        end else if (day_tick) begin
          adv = 1'b1;
        end
      end
      CHECK: begin
        chk      = 1'b1;
        state_nx = RUN;
      end
    endcase
  end

  // Date registers, preset latch and one-cycle pulses
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      day     <= RST_DAY;
      month   <= RST_MON;
      pre     <= '0;
      set_ack <= 1'b0;
      set_err <= 1'b0;
      year_en <= 1'b0;
    end else begin
      set_ack <= 1'b0;
      set_err <= 1'b0;
      year_en <= 1'b0;
      if (latch) begin
        pre.d <= set_day;
        pre.m <= set_month;
      end
      if (chk) begin
        if (pre_ok) begin
          day     <= pre.d;
          month   <= pre.m;
          set_ack <= 1'b1;
        end else begin
          set_err <= 1'b1;
        end
      end
      if (adv) begin
        if (!at_end) begin
          day <= day + 5'd1;
        end else begin
          day <= 5'd1;
          if (month >= 4'd12) begin
            month   <= 4'd1;
            year_en <= 1'b1;
          end else begin
            month <= month + 4'd1;
          end
        end
      end
    end
  end

endmodule
